// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one single-port read memory between two requesters.
// Returning words are steered back to the issuing port by a tag pipe as deep as the read latency.
module mem_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              last_gnt;
  logic              pick0;
  logic              pick1;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_id;
  logic              ret_vld;
  logic              ret_id;

  // Grants are masked by rst_n so nothing is issued while reset is asserted.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (rst_n && !hold) begin
      if (req0 && req1) begin
        pick0 = last_gnt;
        pick1 = ~last_gnt;
      end else begin
        pick0 = req0;
        pick1 = req1;
      end
    end
  end

  assign gnt0     = pick0;
  assign gnt1     = pick1;
  assign mem_en   = pick0 | pick1;
  assign mem_addr = pick0 ? addr0 : (pick1 ? addr1 : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (mem_en) begin
      last_gnt <= pick1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= mem_en;
      tag_id[0]  <= pick1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign ret_vld = tag_vld[RD_LAT-1];
  assign ret_id  = tag_id[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= ret_vld & ~ret_id;
      rvalid1 <= ret_vld & ret_id;
      if (ret_vld && !ret_id) rdata0 <= mem_rdata;
      if (ret_vld && ret_id)  rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream and are
// compared each cycle against a due-cycle scoreboard built from the arbitration rules.
module tb_mem_read_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NC = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;

  logic [1:0] gnt0_d, gnt1_d, rv0_d, rv1_d, men_d;
  logic [1:0][AW-1:0] maddr_d;
  logic [1:0][DW-1:0] rd0_d, rd1_d, mrd_d;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_d[0]), .rvalid0(rv0_d[0]), .rdata0(rd0_d[0]),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_d[0]), .rvalid1(rv1_d[0]), .rdata1(rd1_d[0]),
    .mem_en(men_d[0]), .mem_addr(maddr_d[0]), .mem_rdata(mrd_d[0])
  );

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_d[1]), .rvalid0(rv0_d[1]), .rdata0(rd0_d[1]),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_d[1]), .rvalid1(rv1_d[1]), .rdata1(rd1_d[1]),
    .mem_en(men_d[1]), .mem_addr(maddr_d[1]), .mem_rdata(mrd_d[1])
  );

  // Memory models: data = {24'h0, addr}, presented RD_LAT cycles after the address
  logic [AW-1:0] mq_l1;
  logic [AW-1:0] mq_l3 [3];
  always @(posedge clk) begin
    mq_l1    <= maddr_d[0];
    mq_l3[0] <= maddr_d[1];
    mq_l3[1] <= mq_l3[0];
    mq_l3[2] <= mq_l3[1];
  end
  assign mrd_d[0] = {24'h0, mq_l1};
  assign mrd_d[1] = {24'h0, mq_l3[2]};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_m = 1;
  bit mg0, mg1;
  bit [1:0] sched [2][NC];
  logic [DW-1:0] sdata [2][NC];
  logic [DW-1:0] erd0 [2];
  logic [DW-1:0] erd1 [2];

  task automatic chk(input string tag, input int d, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lat%0d cyc%0d got=%0h exp=%0h", tag, (d == 0) ? 1 : 3, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit [1:0] sch;
    int lat;
    logic [AW-1:0] eaddr;
    @(negedge clk);
    mg0 = 1'b0;
    mg1 = 1'b0;
    if (rst_n && !hold) begin
      if (req0 && req1) begin
        if (last_m == 1) mg0 = 1'b1;
        else mg1 = 1'b1;
      end else if (req0) mg0 = 1'b1;
      else if (req1) mg1 = 1'b1;
    end
    if (!rst_n) begin
      last_m = 1;
      for (int d = 0; d < 2; d++) begin
        erd0[d] = '0;
        erd1[d] = '0;
        for (int c = cyc; c < NC; c++) sched[d][c] = 2'b00;
      end
    end
    eaddr = mg0 ? addr0 : (mg1 ? addr1 : '0);
    for (int d = 0; d < 2; d++) begin
      sch = sched[d][cyc];
      if (sch[0]) erd0[d] = sdata[d][cyc];
      if (sch[1]) erd1[d] = sdata[d][cyc];
      chk("gnt0", d, 32'(gnt0_d[d]), 32'(mg0));
      chk("gnt1", d, 32'(gnt1_d[d]), 32'(mg1));
      chk("mem_en", d, 32'(men_d[d]), 32'(mg0 | mg1));
      chk("mem_addr", d, 32'(maddr_d[d]), 32'(eaddr));
      chk("rvalid0", d, 32'(rv0_d[d]), 32'(sch[0]));
      chk("rvalid1", d, 32'(rv1_d[d]), 32'(sch[1]));
      chk("rdata0", d, rd0_d[d], erd0[d]);
      chk("rdata1", d, rd1_d[d], erd1[d]);
    end
    if (mg0 || mg1) begin
      last_m = mg0 ? 0 : 1;
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? 1 : 3;
        if (cyc + lat + 1 < NC) begin
          sched[d][cyc+lat+1] = {mg1, mg0};
          sdata[d][cyc+lat+1] = {24'h0, eaddr};
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      erd0[d] = '0;
      erd1[d] = '0;
    end
    #1;
    repeat (2) step();
    rst_n = 1'b1;

    // single read from port 0 after reset release
    req0 = 1'b1; addr0 = 8'h05;
    step();
    req0 = 1'b0;
    repeat (5) step();

    // continuous contention, addresses advance after each own grant
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
    repeat (12) begin
      step();
      if (mg0) addr0++;
      if (mg1) addr1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) step();

    // port 1 alone, back-to-back 0x80..0x83
    req1 = 1'b1; addr1 = 8'h80; n = 0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      step();
      if (mg1) begin
        n++;
        addr1++;
      end
    end
    req1 = 1'b0;
    repeat (6) step();

    // reset pulse while a read is in flight
    req0 = 1'b1; addr0 = 8'h33;
    step();
    req0 = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();

    // contention, then hold for 5 cycles after the first grant
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h40; addr1 = 8'h50;
    step();
    if (mg0) addr0++;
    if (mg1) addr1++;
    hold = 1'b1;
    repeat (5) step();
    hold = 1'b0;
    repeat (6) begin
      step();
      if (mg0) addr0++;
      if (mg1) addr1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) step();

    // randomized traffic with hold and occasional reset
    for (int i = 0; i < 600; i++) begin
      step();
      if (!req0 || mg0) begin
        req0 = ($urandom % 4) != 0;
        addr0 = AW'($urandom);
      end
      if (!req1 || mg1) begin
        req1 = ($urandom % 4) != 0;
        addr1 = AW'($urandom);
      end
      hold = ($urandom % 8) == 0;
      rst_n = ($urandom % 200) != 0;
    end
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0; rst_n = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
